dcache_req_scheduler: RTL



---
 rtl/dcache_req_scheduler.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_req_scheduler.sv
// dcache_req_scheduler: front-end for an event-triggered data cache model.
// Arbitrates a processor request FIFO against a single-entry snoop register,
// drives one command at a time onto the cache inputs and returns the captured
// hit/MESI response to whichever requester issued the command.
module dcache_req_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int CLEAR_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [3:0]  cpu_cmd,
    input  logic [31:0] cpu_addr,
    input  logic        snp_valid,
    output logic        snp_ready,
    input  logic [3:0]  snp_cmd,
    input  logic [31:0] snp_addr,
    output logic [3:0]  instruction,
    output logic [11:0] tag,
    output logic [13:0] index,
    output logic [5:0]  byte_offset,
    output logic [31:0] iteration,
    input  logic        hit_miss,
    input  logic [1:0]  MESI_MRU,
    output logic        rsp_valid,
    output logic        rsp_src,
    output logic        rsp_hit,
    output logic [1:0]  rsp_mesi,
    output logic        busy,
    output logic [15:0] err_count
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int CLR_W    = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        CLEAR
    } state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] addr;
    } req_t;

    // Command 8 keeps the cache port reserved while the cache clears itself.
    localparam logic [3:0] CMD_CLEAR = 4'd8;

    state_t              state;
    req_t                fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic                fifo_empty;
    logic                fifo_full;
    req_t                fifo_head;
    req_t                snp_req;
    logic                snp_full;
    logic [STARVE_W-1:0] starve;
    logic [CLR_W-1:0]    clr_cnt;
    logic                cur_src;

    logic                cpu_push;
    logic                cpu_drop;
    logic                snp_push;
    logic                snp_drop;
    logic                grant_snp;
    logic                grant_cpu;
    req_t                win;
    logic [1:0]          err_inc;
    logic [16:0]         err_sum;

    function automatic logic cpu_legal(input logic [3:0] cmd);
        return (cmd == 4'd0) || (cmd == 4'd1) || (cmd == 4'd8) || (cmd == 4'd9);
    endfunction

    function automatic logic snp_legal(input logic [3:0] cmd);
        return (cmd == 4'd3) || (cmd == 4'd4);
    endfunction

    // The extra pointer bit distinguishes full from empty when indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

    // Readiness depends only on stored state, never on same-cycle pops or grants.
    assign cpu_ready = !fifo_full;
    assign snp_ready = !snp_full;
    assign busy      = (state != IDLE);

    assign cpu_push = cpu_valid && cpu_ready && cpu_legal(cpu_cmd);
    assign cpu_drop = cpu_valid && cpu_ready && !cpu_legal(cpu_cmd);
    assign snp_push = snp_valid && snp_ready && snp_legal(snp_cmd);
    assign snp_drop = snp_valid && snp_ready && !snp_legal(snp_cmd);

    assign err_inc = {1'b0, cpu_drop} + {1'b0, snp_drop};
    assign err_sum = {1'b0, err_count} + {15'd0, err_inc};

    // Arbitration: snoop wins unless the processor has been passed over too often.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        grant_snp = 1'b0;
        grant_cpu = 1'b0;
        if (state == IDLE) begin
            if (snp_full && (fifo_empty || (starve < STARVE_W'(STARVE_LIMIT)))) begin
                grant_snp = 1'b1;
            end else if (!fifo_empty) begin
                grant_cpu = 1'b1;
            end
        end
    end

    assign win = grant_snp ? snp_req : fifo_head;

    // Processor FIFO storage.
    // NOTE: the storage array has no reset; the pointers define validity, so stale words are never read.
    always_ff @(posedge clk) begin
        if (cpu_push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{cmd: cpu_cmd, addr: cpu_addr};
        end
    end

    // Processor FIFO pointers: push on a legal handshake, pop on a processor grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
            if (cpu_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_cpu) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Snoop holding register: filled on a legal handshake, drained by a snoop grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snp_full <= 1'b0;
            snp_req  <= '0;
        end else if (snp_push) begin
            snp_full <= 1'b1;
            snp_req  <= '{cmd: snp_cmd, addr: snp_addr};
        end else if (grant_snp) begin
            snp_full <= 1'b0;
        end
    end

    // Saturating count of dropped illegal commands from both ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_sum[16]) begin
            err_count <= 16'hFFFF;
        end else begin
            err_count <= err_sum[15:0];
        end
    end

    // Scheduler FSM: owns the cache inputs, the response registers and the starve counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= 4'hF;
            tag         <= '0;
            index       <= '0;
            byte_offset <= '0;
            iteration   <= '0;
            rsp_valid   <= 1'b0;
            rsp_src     <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_mesi    <= '0;
            starve      <= '0;
            clr_cnt     <= '0;
            cur_src     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_snp || grant_cpu) begin
                        // Cache inputs only ever change on this edge.
                        instruction <= win.cmd;
                        tag         <= win.addr[31:20];
                        index       <= win.addr[19:6];
                        byte_offset <= win.addr[5:0];
                        iteration   <= iteration + 32'd1;
                        cur_src     <= grant_snp;
                        state       <= ISSUE;
                        if (grant_cpu || fifo_empty) begin
                            starve <= '0;
                        end else if (starve != STARVE_W'(STARVE_LIMIT)) begin
                            starve <= starve + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (instruction == CMD_CLEAR) begin
                        // CLEAR lasts CLEAR_CYCLES+1 cycles, so a command-8 slot
                        // spans 4+CLEAR_CYCLES-1 cycles including its IDLE cycle.
                        clr_cnt <= CLR_W'(CLEAR_CYCLES);
                        state   <= CLEAR;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= hit_miss;
                        rsp_mesi  <= MESI_MRU;
                        rsp_src   <= cur_src;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                CLEAR: begin
                    if (clr_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
